// File: rtl/video_scanline_filter.sv
// Scanline filter between a video scaler and its pixel source: requests pass through unchanged,
// returned pixels are darkened (or replaced) on selected rows and columns.
module video_scanline_filter #(
  parameter int unsigned CHUNK_BITS = 5,
  parameter int unsigned RED_BITS   = 5,
  parameter int unsigned GREEN_BITS = 6,
  parameter int unsigned BLUE_BITS  = 5,
  parameter int unsigned QUEUE_BITS = 2,
  localparam int unsigned BITS_PER_PIXEL = RED_BITS + GREEN_BITS + BLUE_BITS,
  localparam int unsigned REQUEST_BITS   = 11 + (11 - CHUNK_BITS)
) (
  input  logic                      scaler_clock_i,
  input  logic                      reset_ni,
  input  logic [1:0]                h_scanline_shift_i,
  input  logic [1:0]                v_scanline_shift_i,
  input  logic [1:0]                scanline_intensity_i,
  input  logic [BITS_PER_PIXEL-1:0] background_color_i,
  output logic                      downstream_request_fifo_read_enable_o,
  input  logic                      downstream_request_fifo_empty_i,
  input  logic [REQUEST_BITS-1:0]   downstream_request_fifo_read_data_i,
  output logic                      downstream_response_fifo_write_enable_o,
  input  logic                      downstream_response_fifo_full_i,
  output logic [BITS_PER_PIXEL-1:0] downstream_response_fifo_write_data_o,
  input  logic                      upstream_request_fifo_read_enable_i,
  output logic                      upstream_request_fifo_empty_o,
  output logic [REQUEST_BITS-1:0]   upstream_request_fifo_read_data_o,
  input  logic                      upstream_response_fifo_write_enable_i,
  output logic                      upstream_response_fifo_full_o,
  input  logic [BITS_PER_PIXEL-1:0] upstream_response_fifo_write_data_i
);

  localparam int unsigned Depth  = 1 << QUEUE_BITS;
  localparam int unsigned CntW   = QUEUE_BITS + 1;
  localparam int unsigned ChunkW = 11 - CHUNK_BITS;
  localparam int unsigned SumW   = CntW + 2;

  // Request side state
  logic                    rd_en_q, rd_en_d, rd_valid_q, ds_read;
  logic [REQUEST_BITS-1:0] req_mem_q [Depth];
  logic [REQUEST_BITS-1:0] out_mem_q [Depth];
  logic [QUEUE_BITS-1:0]   wr_ptr_q, req_rp_q, out_rp_q;
  logic [CntW-1:0]         req_cnt_q, req_cnt_d, out_cnt_q, out_cnt_d, max_cnt;
  logic [SumW-1:0]         committed;
  logic                    req_pop, out_pop;

  // Pixel side state
  logic [CHUNK_BITS-1:0]     pix_cnt_q;
  logic                      full_q, full_d, accept;
  logic [BITS_PER_PIXEL-1:0] sk_mem_q [2];
  logic                      sk_wp_q, sk_rp_q, sk_pop;
  logic [1:0]                sk_cnt_q, sk_cnt_d;

  logic [REQUEST_BITS-1:0]   out_head;
  logic [10:0]               row, column, h_mask, v_mask;
  logic                      scan;
  logic [RED_BITS-1:0]       red;
  logic [GREEN_BITS-1:0]     green;
  logic [BLUE_BITS-1:0]      blue;
  logic [BITS_PER_PIXEL-1:0] pix_out;

  // Reserve a slot for every read already issued or whose data is still arriving.
  always_comb begin
    max_cnt   = (req_cnt_q > out_cnt_q) ? req_cnt_q : out_cnt_q;
    committed = SumW'(max_cnt) + SumW'(rd_valid_q) + SumW'(rd_en_q) + SumW'(1);
    rd_en_d   = ~downstream_request_fifo_empty_i & (committed <= SumW'(Depth));
  end

  // The registered enable is qualified by the live empty flag so a stale decision never
  // pops an empty FIFO when back-to-back reads drain its last entry.
  assign ds_read = rd_en_q & ~downstream_request_fifo_empty_i;
  assign downstream_request_fifo_read_enable_o = ds_read;

  assign req_pop   = upstream_request_fifo_read_enable_i & (req_cnt_q != '0);
  assign accept    = upstream_response_fifo_write_enable_i & ~full_q;
  assign out_pop   = accept & (pix_cnt_q == '1);
  assign req_cnt_d = req_cnt_q + CntW'(rd_valid_q) - CntW'(req_pop);
  assign out_cnt_d = out_cnt_q + CntW'(rd_valid_q) - CntW'(out_pop);

  assign upstream_request_fifo_empty_o     = (req_cnt_q == '0);
  assign upstream_request_fifo_read_data_o = (req_cnt_q == '0) ? '0 : req_mem_q[req_rp_q];

  assign out_head = out_mem_q[out_rp_q];
  assign row      = out_head[REQUEST_BITS-1 -: 11];
  assign column   = {out_head[ChunkW-1:0], pix_cnt_q};
  assign {red, green, blue} = upstream_response_fifo_write_data_i;

  always_comb begin
    h_mask  = (11'd1 << h_scanline_shift_i) - 11'd1;
    v_mask  = (11'd1 << v_scanline_shift_i) - 11'd1;
    scan    = ((h_scanline_shift_i != 2'd0) && ((column & h_mask) == h_mask)) ||
              ((v_scanline_shift_i != 2'd0) && ((row & v_mask) == v_mask));
    pix_out = upstream_response_fifo_write_data_i;
    if (scan) begin
      case (scanline_intensity_i)
        2'd0:    pix_out = {red - (red >> 2), green - (green >> 2), blue - (blue >> 2)};
        2'd1:    pix_out = {red >> 1, green >> 1, blue >> 1};
        2'd2:    pix_out = {red >> 2, green >> 2, blue >> 2};
        default: pix_out = background_color_i;
      endcase
    end
  end

  assign sk_pop   = (sk_cnt_q != 2'd0) & ~downstream_response_fifo_full_i;
  assign sk_cnt_d = sk_cnt_q + 2'(accept) - 2'(sk_pop);
  assign full_d   = (sk_cnt_d == 2'd2) | (out_cnt_d == '0);

  assign downstream_response_fifo_write_enable_o = sk_pop;
  assign downstream_response_fifo_write_data_o   =
      (sk_cnt_q != 2'd0) ? sk_mem_q[sk_rp_q] : '0;
  assign upstream_response_fifo_full_o = full_q;

  // Storage arrays carry no reset; every read of them is gated by its count.
  always_ff @(posedge scaler_clock_i) begin
    if (rd_valid_q) begin
      req_mem_q[wr_ptr_q] <= downstream_request_fifo_read_data_i;
      out_mem_q[wr_ptr_q] <= downstream_request_fifo_read_data_i;
    end
    if (accept) begin
      sk_mem_q[sk_wp_q] <= pix_out;
    end
  end

  always_ff @(posedge scaler_clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rd_en_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      wr_ptr_q   <= '0;
      req_rp_q   <= '0;
      out_rp_q   <= '0;
      req_cnt_q  <= '0;
      out_cnt_q  <= '0;
      pix_cnt_q  <= '0;
      full_q     <= 1'b1;
      sk_wp_q    <= 1'b0;
      sk_rp_q    <= 1'b0;
      sk_cnt_q   <= 2'd0;
    end else begin
      rd_en_q    <= rd_en_d;
      rd_valid_q <= ds_read;
      req_cnt_q  <= req_cnt_d;
      out_cnt_q  <= out_cnt_d;
      sk_cnt_q   <= sk_cnt_d;
      full_q     <= full_d;
      if (rd_valid_q) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (req_pop)    req_rp_q <= req_rp_q + 1'b1;
      if (out_pop)    out_rp_q <= out_rp_q + 1'b1;
      if (accept) begin
        pix_cnt_q <= pix_cnt_q + CHUNK_BITS'(1);
        sk_wp_q   <= ~sk_wp_q;
      end
      if (sk_pop)     sk_rp_q  <= ~sk_rp_q;
    end
  end

endmodule

// File: tb/tb_video_scanline_filter.sv
// Self-checking bench for video_scanline_filter: models both FIFO neighbours and predicts
// every output pixel from row/column arithmetic on the requests it issues.
module tb_video_scanline_filter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  cfg_h = 2'd0, cfg_v = 2'd0, cfg_int = 2'd0;
  logic [15:0] cfg_bg = 16'h0000;
  logic        ds_rd_en, ds_empty, ds_wr_en, up_empty, up_full;
  logic        ds_full = 1'b0, up_rd_en = 1'b0, up_wr_en = 1'b0;
  logic [16:0] ds_rd_data = '0, up_rd_data;
  logic [15:0] ds_wr_data, up_wr_data = '0;

  int errors = 0, checks = 0, cyc = 0, cmp_base = 0;

  // Downstream request FIFO: tasks write ds_wp, the clocked model owns ds_rp.
  logic [16:0] ds_mem [0:255];
  int ds_wp = 0, ds_rp = 0, ds_reads = 0;
  assign ds_empty = (ds_wp == ds_rp);

  logic [15:0] got_pix[$], exp_pix[$];
  int          got_cyc[$], acc_cyc[$];
  logic [16:0] exp_req[$], mdl_req[$];
  int          mdl_idx = 0;

  video_scanline_filter dut (
    .scaler_clock_i                          (clk),
    .reset_ni                                (rst_n),
    .h_scanline_shift_i                      (cfg_h),
    .v_scanline_shift_i                      (cfg_v),
    .scanline_intensity_i                    (cfg_int),
    .background_color_i                      (cfg_bg),
    .downstream_request_fifo_read_enable_o   (ds_rd_en),
    .downstream_request_fifo_empty_i         (ds_empty),
    .downstream_request_fifo_read_data_i     (ds_rd_data),
    .downstream_response_fifo_write_enable_o (ds_wr_en),
    .downstream_response_fifo_full_i         (ds_full),
    .downstream_response_fifo_write_data_o   (ds_wr_data),
    .upstream_request_fifo_read_enable_i     (up_rd_en),
    .upstream_request_fifo_empty_o           (up_empty),
    .upstream_request_fifo_read_data_o       (up_rd_data),
    .upstream_response_fifo_write_enable_i   (up_wr_en),
    .upstream_response_fifo_full_o           (up_full),
    .upstream_response_fifo_write_data_i     (up_wr_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ds_rd_en === 1'b1) begin
      ds_rd_data <= ds_mem[ds_rp];
      ds_rp      <= ds_rp + 1;
      ds_reads   <= ds_reads + 1;
    end
  end

  // Stamp is the clock edge at which the downstream write is consumed.
  always @(negedge clk) begin
    #1;
    if (ds_wr_en === 1'b1) begin
      got_pix.push_back(ds_wr_data);
      got_cyc.push_back(cyc + 1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] model_pixel(input logic [16:0] req, input int idx,
                                              input logic [15:0] pix);
    int  row, col, hp, vp, r, g, b;
    bit  scan;
    row  = int'(req[16:6]);
    col  = int'(req[5:0]) * 32 + idx;
    hp   = 1 << cfg_h;
    vp   = 1 << cfg_v;
    scan = (cfg_h != 0 && col % hp == hp - 1) || (cfg_v != 0 && row % vp == vp - 1);
    r = int'(pix[15:11]);
    g = int'(pix[10:5]);
    b = int'(pix[4:0]);
    if (!scan) return pix;
    case (cfg_int)
      2'd0: begin r = r - r / 4; g = g - g / 4; b = b - b / 4; end
      2'd1: begin r = r / 2; g = g / 2; b = b / 2; end
      2'd2: begin r = r / 4; g = g / 4; b = b / 4; end
      default: return cfg_bg;
    endcase
    return 16'(r * 2048 + g * 32 + b);
  endfunction

  task automatic load_request(input logic [16:0] r);
    ds_mem[ds_wp] = r;
    ds_wp = ds_wp + 1;
    exp_req.push_back(r);
    mdl_req.push_back(r);
  endtask

  task automatic pop_request(output logic [16:0] d, output bit ok);
    int n = 0;
    ok = 1'b0;
    d  = '0;
    while (up_empty !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (up_empty === 1'b0) begin
      ok = 1'b1;
      d  = up_rd_data;
      up_rd_en = 1'b1;
      @(negedge clk);
      up_rd_en = 1'b0;
    end
  endtask

  task automatic send_pixels(input int n, input bit rnd, input logic [15:0] val,
                             input int gap_pct, input int bp_pct, output bit timeout);
    int          sent = 0;
    int          budget = n * 40 + 200;
    logic [15:0] pix;
    while (sent < n && budget > 0) begin
      ds_full  = (bp_pct > 0) ? ($urandom_range(0, 99) < bp_pct) : 1'b0;
      up_wr_en = 1'b0;
      if ($urandom_range(0, 99) >= gap_pct) begin
        pix = rnd ? 16'($urandom) : val;
        up_wr_en   = 1'b1;
        up_wr_data = pix;
        if (up_full === 1'b0) begin
          exp_pix.push_back(mdl_req.size() > 0 ? model_pixel(mdl_req[0], mdl_idx, pix) : pix);
          acc_cyc.push_back(cyc + 1);
          mdl_idx++;
          if (mdl_idx == 32) begin
            mdl_idx = 0;
            if (mdl_req.size() > 0) void'(mdl_req.pop_front());
          end
          sent++;
        end
      end
      @(negedge clk);
      budget--;
    end
    up_wr_en = 1'b0;
    ds_full  = 1'b0;
    timeout  = (sent < n);
  endtask

  task automatic drain(output bit timeout);
    int n = 0;
    ds_full = 1'b0;
    while (got_pix.size() < exp_pix.size() && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    timeout = (got_pix.size() < exp_pix.size());
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks += 6;
    if (ds_rd_en !== 1'b0) begin errors++; $display("FAIL rst_rd_en got=%b want=0", ds_rd_en); end
    if (ds_wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en got=%b want=0", ds_wr_en); end
    if (ds_wr_data !== 16'h0) begin
      errors++; $display("FAIL rst_wr_data got=%h want=0000", ds_wr_data);
    end
    if (up_empty !== 1'b1) begin errors++; $display("FAIL rst_empty got=%b want=1", up_empty); end
    if (up_full !== 1'b1) begin errors++; $display("FAIL rst_full got=%b want=1", up_full); end
    if (up_rd_data !== 17'h0) begin
      errors++; $display("FAIL rst_rd_data got=%h want=0", up_rd_data);
    end
    load_request({11'd5, 6'd2});
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (ds_reads !== 0) begin
      errors++; $display("FAIL first_read_edge reads=%0d want=0 after first edge", ds_reads);
    end
    @(negedge clk);
  endtask

  task automatic test_pass_through;
    logic [16:0] d;
    bit ok, to;
    pop_request(d, ok);
    checks++;
    if (!ok || d !== 17'({11'd5, 6'd2})) begin
      errors++; $display("FAIL pass_req got=%h ok=%0d want=%h", d, ok, 17'({11'd5, 6'd2}));
    end
    void'(exp_req.pop_front());
    send_pixels(32, 1'b0, 16'h1234, 0, 0, to);
    drain(to);
    checks++;
    if (to || got_pix.size() != cmp_base + 32) begin
      errors++; $display("FAIL pass_count got=%0d want=%0d", got_pix.size() - cmp_base, 32);
    end
    for (int i = cmp_base; i < cmp_base + 32 && i < got_pix.size(); i++) begin
      checks += 2;
      if (got_pix[i] !== 16'h1234) begin
        errors++; $display("FAIL pass_pix[%0d] got=%h want=1234", i - cmp_base, got_pix[i]);
      end
      if (got_cyc[i] - acc_cyc[i] != 1) begin
        errors++;
        $display("FAIL pass_latency[%0d] got=%0d want=1", i - cmp_base, got_cyc[i] - acc_cyc[i]);
      end
    end
    cmp_base = exp_pix.size();
  endtask

  task automatic test_row_scanline;
    logic [16:0] d;
    bit ok, to;
    logic [15:0] want;
    cfg_h = 2'd0; cfg_v = 2'd1; cfg_int = 2'd1;
    load_request({11'd2, 6'd0});
    load_request({11'd3, 6'd0});
    for (int k = 0; k < 2; k++) begin
      pop_request(d, ok);
      checks++;
      if (!ok || d !== exp_req[0]) begin
        errors++; $display("FAIL row_req got=%h ok=%0d want=%h", d, ok, exp_req[0]);
      end
      void'(exp_req.pop_front());
    end
    send_pixels(64, 1'b0, 16'hFFFF, 30, 0, to);
    drain(to);
    checks++;
    if (to || got_pix.size() != cmp_base + 64) begin
      errors++; $display("FAIL row_count got=%0d want=64", got_pix.size() - cmp_base);
    end
    for (int i = cmp_base; i < cmp_base + 64 && i < got_pix.size(); i++) begin
      want = (i - cmp_base < 32) ? 16'hFFFF : 16'h7BEF;
      checks++;
      if (got_pix[i] !== want) begin
        errors++; $display("FAIL row_pix[%0d] got=%h want=%h", i - cmp_base, got_pix[i], want);
      end
    end
    cmp_base = exp_pix.size();
  endtask

  task automatic test_column_scanline;
    logic [16:0] d;
    bit ok, to;
    logic [15:0] want;
    cfg_h = 2'd2; cfg_v = 2'd0; cfg_int = 2'd3; cfg_bg = 16'h0000;
    load_request({11'd0, 6'd0});
    pop_request(d, ok);
    checks++;
    if (!ok || d !== exp_req[0]) begin
      errors++; $display("FAIL col_req got=%h ok=%0d want=%h", d, ok, exp_req[0]);
    end
    void'(exp_req.pop_front());
    send_pixels(32, 1'b0, 16'hFFFF, 0, 20, to);
    drain(to);
    checks++;
    if (to || got_pix.size() != cmp_base + 32) begin
      errors++; $display("FAIL col_count got=%0d want=32", got_pix.size() - cmp_base);
    end
    for (int i = cmp_base; i < cmp_base + 32 && i < got_pix.size(); i++) begin
      want = ((i - cmp_base) % 4 == 3) ? 16'h0000 : 16'hFFFF;
      checks++;
      if (got_pix[i] !== want) begin
        errors++; $display("FAIL col_pix[%0d] got=%h want=%h", i - cmp_base, got_pix[i], want);
      end
    end
    cmp_base = exp_pix.size();
  endtask

  task automatic test_darken_25;
    logic [16:0] d;
    bit ok, to;
    cfg_h = 2'd0; cfg_v = 2'd1; cfg_int = 2'd0;
    load_request({11'd1, 6'($urandom_range(0, 63))});
    pop_request(d, ok);
    void'(exp_req.pop_front());
    send_pixels(32, 1'b0, 16'hFFFF, 10, 0, to);
    drain(to);
    checks++;
    if (!ok || to || got_pix.size() != cmp_base + 32) begin
      errors++; $display("FAIL dark_count got=%0d want=32", got_pix.size() - cmp_base);
    end
    for (int i = cmp_base; i < cmp_base + 32 && i < got_pix.size(); i++) begin
      checks++;
      if (got_pix[i] !== 16'hC618) begin
        errors++; $display("FAIL dark_pix[%0d] got=%h want=c618", i - cmp_base, got_pix[i]);
      end
    end
    cmp_base = exp_pix.size();
  endtask

  task automatic test_backpressure;
    logic [16:0] d;
    bit ok, to;
    logic [15:0] pix;
    int held;
    cfg_h = 2'd1; cfg_v = 2'd0; cfg_int = 2'd2;
    load_request({11'($urandom_range(0, 2047)), 6'($urandom_range(0, 63))});
    pop_request(d, ok);
    void'(exp_req.pop_front());
    send_pixels(10, 1'b1, 16'h0, 0, 0, to);
    held = 0;
    for (int k = 0; k < 10; k++) begin
      ds_full    = 1'b1;
      pix        = 16'($urandom);
      up_wr_en   = 1'b1;
      up_wr_data = pix;
      if (up_full === 1'b0) begin
        exp_pix.push_back(model_pixel(mdl_req[0], mdl_idx, pix));
        acc_cyc.push_back(cyc + 1);
        mdl_idx++;
        held++;
      end
      @(negedge clk);
    end
    up_wr_en = 1'b0;
    checks += 2;
    if (up_full !== 1'b1) begin errors++; $display("FAIL bp_full got=%b want=1", up_full); end
    if (exp_pix.size() - got_pix.size() != 2) begin
      errors++;
      $display("FAIL bp_buffered got=%0d want=2", exp_pix.size() - got_pix.size());
    end
    send_pixels(32 - 10 - held, 1'b1, 16'h0, 20, 0, to);
    drain(to);
    checks++;
    if (!ok || to || got_pix.size() != exp_pix.size()) begin
      errors++; $display("FAIL bp_count got=%0d want=%0d", got_pix.size(), exp_pix.size());
    end
    for (int i = cmp_base; i < exp_pix.size() && i < got_pix.size(); i++) begin
      checks++;
      if (got_pix[i] !== exp_pix[i]) begin
        errors++; $display("FAIL bp_pix[%0d] got=%h want=%h", i - cmp_base, got_pix[i], exp_pix[i]);
      end
    end
    cmp_base = exp_pix.size();
  endtask

  task automatic test_random;
    logic [16:0] d;
    bit ok, to;
    for (int it = 0; it < 4; it++) begin
      cfg_h = 2'($urandom); cfg_v = 2'($urandom); cfg_int = 2'($urandom);
      cfg_bg = 16'($urandom);
      for (int k = 0; k < 2; k++) begin
        load_request({11'($urandom_range(0, 2047)), 6'($urandom_range(0, 63))});
      end
      for (int k = 0; k < 2; k++) begin
        pop_request(d, ok);
        checks++;
        if (!ok || d !== exp_req[0]) begin
          errors++; $display("FAIL rnd_req got=%h ok=%0d want=%h", d, ok, exp_req[0]);
        end
        void'(exp_req.pop_front());
      end
      send_pixels(64, 1'b1, 16'h0, 25, 30, to);
      drain(to);
      checks++;
      if (to || got_pix.size() != exp_pix.size()) begin
        errors++; $display("FAIL rnd_count got=%0d want=%0d", got_pix.size(), exp_pix.size());
      end
      for (int i = cmp_base; i < exp_pix.size() && i < got_pix.size(); i++) begin
        checks++;
        if (got_pix[i] !== exp_pix[i]) begin
          errors++;
          $display("FAIL rnd_pix[%0d] got=%h want=%h cfg=%0d/%0d/%0d", i - cmp_base,
                   got_pix[i], exp_pix[i], cfg_h, cfg_v, cfg_int);
        end
      end
      cmp_base = exp_pix.size();
    end
  endtask

  task automatic test_queue_limit;
    int reads0;
    bit to;
    cfg_h = 2'd0; cfg_v = 2'd0; cfg_int = 2'd0;
    reads0 = ds_reads;
    for (int k = 0; k < 6; k++) load_request({11'(k + 100), 6'(k)});
    repeat (30) @(negedge clk);
    checks += 2;
    if (ds_reads - reads0 != 4) begin
      errors++; $display("FAIL qlim_reads got=%0d want=4", ds_reads - reads0);
    end
    if (up_empty !== 1'b0) begin errors++; $display("FAIL qlim_empty got=%b want=0", up_empty); end
    send_pixels(10, 1'b1, 16'h0, 0, 0, to);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks += 6;
    if (ds_rd_en !== 1'b0) begin errors++; $display("FAIL mid_rd_en got=%b want=0", ds_rd_en); end
    if (ds_wr_en !== 1'b0) begin errors++; $display("FAIL mid_wr_en got=%b want=0", ds_wr_en); end
    if (ds_wr_data !== 16'h0) begin
      errors++; $display("FAIL mid_wr_data got=%h want=0000", ds_wr_data);
    end
    if (up_empty !== 1'b1) begin errors++; $display("FAIL mid_empty got=%b want=1", up_empty); end
    if (up_full !== 1'b1) begin errors++; $display("FAIL mid_full got=%b want=1", up_full); end
    if (up_rd_data !== 17'h0) begin
      errors++; $display("FAIL mid_rd_data got=%h want=0", up_rd_data);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_row_scanline();
    test_column_scanline();
    test_darken_25();
    test_backpressure();
    test_random();
    test_queue_limit();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
